// File: rtl/zube_pkg.sv
// Shared constants for the zube Z80 mailbox: FSM encodings, status bit layout
// and port offsets relative to the base I/O address.
package zube_pkg;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WRITE    = 2'd1;
   localparam logic [1:0] S_READ     = 2'd2;
   localparam logic [1:0] S_READ_END = 2'd3;

   localparam int ST_H2Z_AVAIL = 0;
   localparam int ST_Z2H_FULL  = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_UNF       = 3;

   localparam logic [7:0] DATA_PORT_OFS   = 8'd0;
   localparam logic [7:0] STATUS_PORT_OFS = 8'd1;

endpackage

// File: rtl/zube_mailbox_ctrl_if.sv
// Z80 I/O pins and host byte-stream handshakes of the zube mailbox.
// The block is the slave; the host/Z80 side (or a bench) is the master.
interface zube_mailbox_ctrl_if;
   logic [7:0] z80_addr;
   logic [7:0] z80_data_in;
   logic [7:0] z80_data_out;
   logic       z80_wr_b;
   logic       z80_rd_b;
   logic       z80_bus_dir;
   logic       host_tx_valid;
   logic [7:0] host_tx_data;
   logic       host_tx_ready;
   logic       host_rx_valid;
   logic [7:0] host_rx_data;
   logic       host_rx_ready;
   logic       irq;

   modport slave (
      input  z80_addr, z80_data_in, z80_wr_b, z80_rd_b,
      input  host_tx_valid, host_tx_data, host_rx_ready,
      output z80_data_out, z80_bus_dir, host_tx_ready,
      output host_rx_valid, host_rx_data, irq
   );

   modport master (
      output z80_addr, z80_data_in, z80_wr_b, z80_rd_b,
      output host_tx_valid, host_tx_data, host_rx_ready,
      input  z80_data_out, z80_bus_dir, host_tx_ready,
      input  host_rx_valid, host_rx_data, irq
   );
endinterface

// File: rtl/zube_sync_fifo.sv
// Single-clock byte FIFO; overflowing pushes and underflowing pops are ignored.
// Pointers carry one extra MSB so full and empty can be told apart on wrap.
module zube_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head      = mem_r[rd_ptr_r[AW-1:0]];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Storage and pointer update; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end
endmodule

// File: rtl/zube_mailbox_ctrl.sv
// Z80 I/O slave for the zube mailbox: synchronises the Z80 strobes, decodes the
// data/status ports and moves bytes through the Z2H and H2Z FIFOs.
module zube_mailbox_ctrl
   import zube_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR  = 8'h80,
   parameter int         FIFO_DEPTH = 4
) (
   input logic           wb_clk_i,
   input logic           wb_rst_ni,
   zube_mailbox_ctrl_if.slave bus
);
   localparam logic [7:0] DATA_ADDR   = BASE_ADDR + DATA_PORT_OFS;
   localparam logic [7:0] STATUS_ADDR = BASE_ADDR + STATUS_PORT_OFS;

   logic [1:0] wr_sync_r, rd_sync_r;
   logic       wr_dly_r, rd_dly_r;
   logic       wr_s, rd_s, wr_fall_s, rd_fall_s, wr_rise_s, rd_rise_s, proto_err_s;

   logic [1:0] state_r, state_n;
   logic [7:0] data_out_r, data_out_n;
   logic       bus_dir_r, bus_dir_n;
   logic       ovf_r, ovf_n, unf_r, unf_n;
   logic       pop_pend_r, pop_pend_n, clr_st_r, clr_st_n;
   logic [7:0] status_s;

   logic       z2h_push_s, z2h_pop_s, z2h_full_s, z2h_empty_s;
   logic       h2z_push_s, h2z_pop_s, h2z_full_s, h2z_empty_s;
   logic [7:0] z2h_head_s, h2z_head_s;

   assign wr_s        = wr_sync_r[1];
   assign rd_s        = rd_sync_r[1];
   assign wr_fall_s   = wr_dly_r & ~wr_s;
   assign rd_fall_s   = rd_dly_r & ~rd_s;
   assign wr_rise_s   = ~wr_dly_r & wr_s;
   assign rd_rise_s   = ~rd_dly_r & rd_s;
   assign proto_err_s = ~wr_s & ~rd_s;

   // Two-flop synchronisers plus an edge-detect stage, idling high like the pins.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wr_sync_r <= 2'b11;
         rd_sync_r <= 2'b11;
         wr_dly_r  <= 1'b1;
         rd_dly_r  <= 1'b1;
      end else begin
         wr_sync_r <= {wr_sync_r[0], bus.z80_wr_b};
         rd_sync_r <= {rd_sync_r[0], bus.z80_rd_b};
         wr_dly_r  <= wr_s;
         rd_dly_r  <= rd_s;
      end
   end

   // Status byte as the Z80 sees it at the start of a status read.
   always_comb begin
      status_s               = 8'h00;
      status_s[ST_H2Z_AVAIL] = ~h2z_empty_s;
      status_s[ST_Z2H_FULL]  = z2h_full_s;
      status_s[ST_OVF]       = ovf_r;
      status_s[ST_UNF]       = unf_r;
   end

   // Bus sequencing FSM; the H2Z pop is deferred to READ_END so data stays stable.
   always_comb begin
      state_n    = state_r;
      data_out_n = data_out_r;
      bus_dir_n  = bus_dir_r;
      ovf_n      = ovf_r;
      unf_n      = unf_r;
      pop_pend_n = pop_pend_r;
      clr_st_n   = clr_st_r;
      z2h_push_s = 1'b0;
      h2z_pop_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (proto_err_s) begin
               state_n = S_IDLE;
            end else if (wr_fall_s) begin
               state_n = S_WRITE;
               if (bus.z80_addr == DATA_ADDR) begin
                  z2h_push_s = 1'b1;
                  ovf_n      = ovf_r | z2h_full_s;
               end else begin
                  z2h_push_s = 1'b0;
               end
            end else if (rd_fall_s) begin
               state_n    = S_READ;
               pop_pend_n = 1'b0;
               clr_st_n   = 1'b0;
               if (bus.z80_addr == DATA_ADDR) begin
                  bus_dir_n = 1'b1;
                  if (h2z_empty_s) begin
                     data_out_n = 8'hFF;
                     unf_n      = 1'b1;
                  end else begin
                     data_out_n = h2z_head_s;
                     pop_pend_n = 1'b1;
                  end
               end else if (bus.z80_addr == STATUS_ADDR) begin
                  bus_dir_n  = 1'b1;
                  data_out_n = status_s;
                  clr_st_n   = 1'b1;
               end else begin
                  bus_dir_n = 1'b0;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_WRITE: begin
            if (wr_rise_s) begin
               state_n = S_IDLE;
            end else begin
               state_n = S_WRITE;
            end
         end
         S_READ: begin
            if (rd_rise_s) begin
               state_n = S_READ_END;
            end else begin
               state_n = S_READ;
            end
         end
         S_READ_END: begin
            state_n   = S_IDLE;
            bus_dir_n = 1'b0;
            h2z_pop_s = pop_pend_r;
            if (clr_st_r) begin
               ovf_n = 1'b0;
               unf_n = 1'b0;
            end else begin
               ovf_n = ovf_r;
            end
         end
         default: begin
            state_n   = S_IDLE;
            bus_dir_n = 1'b0;
         end
      endcase
   end

   // FSM and registered Z80-facing outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_r    <= S_IDLE;
         data_out_r <= 8'hFF;
         bus_dir_r  <= 1'b0;
         ovf_r      <= 1'b0;
         unf_r      <= 1'b0;
         pop_pend_r <= 1'b0;
         clr_st_r   <= 1'b0;
      end else begin
         state_r    <= state_n;
         data_out_r <= data_out_n;
         bus_dir_r  <= bus_dir_n;
         ovf_r      <= ovf_n;
         unf_r      <= unf_n;
         pop_pend_r <= pop_pend_n;
         clr_st_r   <= clr_st_n;
      end
   end

   assign h2z_push_s = bus.host_tx_valid & ~h2z_full_s;
   assign z2h_pop_s  = ~z2h_empty_s & bus.host_rx_ready;

   zube_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_z2h (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (z2h_push_s),
      .push_data (bus.z80_data_in),
      .pop       (z2h_pop_s),
      .head      (z2h_head_s),
      .full      (z2h_full_s),
      .empty     (z2h_empty_s)
   );

   zube_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_h2z (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (h2z_push_s),
      .push_data (bus.host_tx_data),
      .pop       (h2z_pop_s),
      .head      (h2z_head_s),
      .full      (h2z_full_s),
      .empty     (h2z_empty_s)
   );

   assign bus.z80_data_out  = data_out_r;
   assign bus.z80_bus_dir   = bus_dir_r;
   assign bus.host_tx_ready = ~h2z_full_s;
   assign bus.host_rx_valid = ~z2h_empty_s;
   assign bus.host_rx_data  = z2h_head_s;
   assign bus.irq           = ~z2h_empty_s;
endmodule

// File: tb/tb_zube_mailbox_ctrl.sv
// Scoreboard bench for zube_mailbox_ctrl: stimulus queues expected Z80 read bytes
// and host receive bytes; two monitors compare them when the DUT presents data.
module tb_zube_mailbox_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [7:0] exp_rd_q[$];
   logic [7:0] exp_rx_q[$];
   logic       prev_dir = 1'b0;
   logic [7:0] held_data = 8'h00;

   zube_mailbox_ctrl_if bus_if ();

   zube_mailbox_ctrl #(.BASE_ADDR(8'h80), .FIFO_DEPTH(4)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Z80 read monitor: compare the byte when the bus turns around, then hold stable.
   always @(negedge clk) begin
      if (bus_if.z80_bus_dir && !prev_dir) begin
         if (exp_rd_q.size() == 0) begin
            check("unexpected_drive", 32'd1, 32'd0);
         end else begin
            check("z80_rd_data", {24'd0, bus_if.z80_data_out}, {24'd0, exp_rd_q.pop_front()});
         end
         held_data = bus_if.z80_data_out;
      end else if (bus_if.z80_bus_dir && prev_dir) begin
         check("z80_rd_hold", {24'd0, bus_if.z80_data_out}, {24'd0, held_data});
      end
      prev_dir = bus_if.z80_bus_dir;
   end

   // Host receive monitor: compare the head byte on every accepted pop.
   always @(negedge clk) begin
      if (rst_n && bus_if.host_rx_valid && bus_if.host_rx_ready) begin
         if (exp_rx_q.size() == 0) begin
            check("unexpected_rx", 32'd1, 32'd0);
         end else begin
            check("host_rx_data", {24'd0, bus_if.host_rx_data}, {24'd0, exp_rx_q.pop_front()});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic z80_write(input logic [7:0] addr, input logic [7:0] data);
      bus_if.z80_addr = addr;
      bus_if.z80_data_in = data;
      bus_if.z80_wr_b = 1'b0;
      cycles(6);
      bus_if.z80_wr_b = 1'b1;
      cycles(6);
   endtask

   task automatic z80_read(input logic [7:0] addr, input bit drives, input logic [7:0] exp);
      if (drives) exp_rd_q.push_back(exp);
      bus_if.z80_addr = addr;
      bus_if.z80_rd_b = 1'b0;
      cycles(6);
      if (!drives) check("no_drive", {31'd0, bus_if.z80_bus_dir}, 32'd0);
      bus_if.z80_rd_b = 1'b1;
      cycles(6);
      check("dir_released", {31'd0, bus_if.z80_bus_dir}, 32'd0);
   endtask

   task automatic host_push(input logic [7:0] data);
      @(posedge clk); #1;
      bus_if.host_tx_valid = 1'b1;
      bus_if.host_tx_data = data;
      @(posedge clk); #1;
      bus_if.host_tx_valid = 1'b0;
   endtask

   task automatic host_pop();
      @(posedge clk); #1;
      bus_if.host_rx_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.host_rx_ready = 1'b0;
   endtask

   initial begin
      bit seen;
      bus_if.z80_addr = 8'h00;
      bus_if.z80_data_in = 8'h00;
      bus_if.z80_wr_b = 1'b1;
      bus_if.z80_rd_b = 1'b1;
      bus_if.host_tx_valid = 1'b0;
      bus_if.host_tx_data = 8'h00;
      bus_if.host_rx_ready = 1'b0;
      cycles(3);
      check("rst_data_out", {24'd0, bus_if.z80_data_out}, 32'hFF);
      check("rst_bus_dir", {31'd0, bus_if.z80_bus_dir}, 32'd0);
      check("rst_tx_ready", {31'd0, bus_if.host_tx_ready}, 32'd1);
      check("rst_rx_valid", {31'd0, bus_if.host_rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, bus_if.host_rx_data}, 32'd0);
      check("rst_irq", {31'd0, bus_if.irq}, 32'd0);
      rst_n = 1'b1;
      cycles(2);

      // Z80 write reaches the host and raises irq within 4 cycles.
      exp_rx_q.push_back(8'h5A);
      bus_if.z80_addr = 8'h80;
      bus_if.z80_data_in = 8'h5A;
      bus_if.z80_wr_b = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         cycles(1);
         seen = bus_if.irq;
      end
      check("irq_latency", {31'd0, seen}, 32'd1);
      check("rx_valid_after_wr", {31'd0, bus_if.host_rx_valid}, 32'd1);
      cycles(3);
      bus_if.z80_wr_b = 1'b1;
      cycles(6);
      host_pop();
      check("irq_cleared", {31'd0, bus_if.irq}, 32'd0);

      // Host to Z80 ordering, then a clean status byte.
      host_push(8'h11);
      host_push(8'h22);
      z80_read(8'h80, 1'b1, 8'h11);
      z80_read(8'h80, 1'b1, 8'h22);
      z80_read(8'h81, 1'b1, 8'h00);

      // Overflow: the fifth byte is dropped; status clears on read.
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_rx_q.push_back(8'hA1 + 8'(i));
         z80_write(8'h80, 8'hA1 + 8'(i));
      end
      z80_read(8'h81, 1'b1, 8'h06);
      z80_read(8'h81, 1'b1, 8'h02);
      for (int i = 0; i < 4; i++) host_pop();
      check("z2h_drained", {31'd0, bus_if.host_rx_valid}, 32'd0);

      // Underflow: 0xFF, sticky bit3, and no pointer movement.
      z80_read(8'h80, 1'b1, 8'hFF);
      z80_read(8'h81, 1'b1, 8'h08);
      z80_read(8'h81, 1'b1, 8'h00);
      host_push(8'h33);
      z80_read(8'h80, 1'b1, 8'h33);

      // Foreign addresses and a protocol error leave everything untouched.
      z80_write(8'h42, 8'h99);
      check("foreign_wr", {31'd0, bus_if.host_rx_valid}, 32'd0);
      z80_read(8'h43, 1'b0, 8'h00);
      bus_if.z80_addr = 8'h80;
      bus_if.z80_data_in = 8'h77;
      bus_if.z80_wr_b = 1'b0;
      bus_if.z80_rd_b = 1'b0;
      cycles(8);
      check("proto_no_push", {31'd0, bus_if.host_rx_valid}, 32'd0);
      check("proto_no_drive", {31'd0, bus_if.z80_bus_dir}, 32'd0);
      bus_if.z80_wr_b = 1'b1;
      bus_if.z80_rd_b = 1'b1;
      cycles(6);
      z80_read(8'h81, 1'b1, 8'h00);
      host_push(8'h44);
      z80_read(8'h80, 1'b1, 8'h44);

      // Reset in the middle of a driven read.
      host_push(8'h55);
      z80_write(8'h80, 8'h66);
      exp_rd_q.push_back(8'h55);
      bus_if.z80_addr = 8'h80;
      bus_if.z80_rd_b = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycles(1);
         seen = bus_if.z80_bus_dir;
      end
      check("dir_before_reset", {31'd0, seen}, 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_dir_drop", {31'd0, bus_if.z80_bus_dir}, 32'd0);
      exp_rx_q.delete();
      check("rst_z2h_flushed", {31'd0, bus_if.host_rx_valid}, 32'd0);
      check("rst_h2z_flushed", {31'd0, bus_if.host_tx_ready}, 32'd1);
      check("rst_irq_mid", {31'd0, bus_if.irq}, 32'd0);
      check("rst_data_mid", {24'd0, bus_if.z80_data_out}, 32'hFF);
      bus_if.z80_rd_b = 1'b1;
      cycles(2);
      rst_n = 1'b1;
      cycles(4);
      z80_read(8'h80, 1'b1, 8'hFF);
      z80_read(8'h81, 1'b1, 8'h08);

      cycles(4);
      check("rd_queue_empty", exp_rd_q.size(), 32'd0);
      check("rx_queue_empty", exp_rx_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
